inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/enc_pkg.sv | 29 ++
 rtl/enc_fifo.sv | 74 +++++++
 rtl/inst_encoder.sv | 86 ++++++++
 tb/tb_inst_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and the R-type word layout for the instruction encoder.
package enc_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = 2;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned CTRL_W     = 4;
   localparam int unsigned ERR_W      = 8;

   localparam logic [6:0] OPCODE_R    = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   localparam logic [2:0] F3_SUB = 3'b000;
   localparam logic [2:0] F3_SRA = 3'b101;

   typedef struct packed {
      logic [6:0]       funct7;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rs1;
      logic [2:0]       funct3;
      logic [REG_W-1:0] rd;
      logic [6:0]       opcode;
   } rtype_t;

endpackage

// File: rtl/enc_fifo.sv
// Four-entry word FIFO with wrapping pointers and registered occupancy flags.
module enc_fifo
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              valid,
   output logic              ready,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   logic              do_push;
   logic              do_pop;

   // Pointer, storage and occupancy update; a push and pop together keep count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && ready_q;
      do_pop   = pop && valid_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != CNT_W'(0));
      ready_d = (count_d != CNT_W'(FIFO_DEPTH));
   end

   // State registers; reset empties the buffer and leaves it ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign valid = valid_q;
   assign ready = ready_q;
   assign count = count_q;

endmodule

// File: rtl/inst_encoder.sv
// R-type instruction encoder with legality check, error counter and output FIFO.
// Optional RV32M encoding is enabled by defining INST_ENCODER_MEXT_EN.
module inst_encoder
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [CTRL_W-1:0] in_alu_ctrl,
   input  logic              in_mext,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [CNT_W-1:0]  count,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt
);

   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   rtype_t           word;
   logic             alt;
   logic             illegal;
   logic             accept;
   logic             push;

   // Encode the request, classify legality and track the error pulse/count.
   always_comb begin
      alt         = in_alu_ctrl[3];
      word.opcode = OPCODE_R;
      word.rd     = in_rd;
      word.funct3 = in_alu_ctrl[2:0];
      word.rs1    = in_rs1;
      word.rs2    = in_rs2;
      word.funct7 = alt ? FUNCT7_ALT : FUNCT7_BASE;
      illegal     = alt && !((word.funct3 == F3_SUB) || (word.funct3 == F3_SRA));
`ifdef INST_ENCODER_MEXT_EN
      if (in_mext) begin
         word.funct7 = FUNCT7_MEXT;
         illegal     = alt;
      end
`else
      if (in_mext) begin
         illegal = 1'b1;
      end
`endif
      accept    = in_valid && in_ready;
      push      = accept && !illegal;
      err_d     = accept && illegal;
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != ERR_W'(255))) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   // Error pulse and saturating counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   enc_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (word),
      .pop   (out_ready),
      .rdata (out_inst),
      .valid (out_valid),
      .ready (in_ready),
      .count (count)
   );

   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed, table-driven bench for inst_encoder.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [3:0]  in_alu_ctrl;
   logic        in_mext;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [2:0]  count;
   logic        err;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_err_cnt = 0;

   typedef struct {
      logic [4:0]  rd, rs1, rs2;
      logic [3:0]  ctrl;
      logic        mext;
      logic        ill;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   inst_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_alu_ctrl (in_alu_ctrl),
      .in_mext     (in_mext),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .count       (count),
      .err         (err),
      .err_cnt     (err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [3:0] ctrl, input logic mext, input logic ill,
                               input logic [31:0] exp);
      vec_t v;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ctrl = ctrl;
      v.mext = mext; v.ill = ill; v.exp = exp;
      return v;
   endfunction

   function automatic logic [31:0] add_word(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   task automatic drive_req(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [3:0] ctrl, input logic mext);
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_alu_ctrl = ctrl; in_mext = mext;
   endtask

   logic [31:0] words [5];
   logic [31:0] exp_q [$];

   initial begin
      vecs[0] = mk(5'd3,  5'd1,  5'd2,  4'b0000, 1'b0, 1'b0, 32'h002081B3);  // ADD
      vecs[1] = mk(5'd5,  5'd6,  5'd7,  4'b1000, 1'b0, 1'b0, 32'h407302B3);  // SUB
      vecs[2] = mk(5'd10, 5'd11, 5'd12, 4'b1101, 1'b0, 1'b0, 32'h40C5D533);  // SRA
      vecs[3] = mk(5'd31, 5'd31, 5'd31, 4'b0111, 1'b0, 1'b0, 32'h01FFFFB3);  // AND
      vecs[4] = mk(5'd0,  5'd0,  5'd0,  4'b0001, 1'b0, 1'b0, 32'h00001033);  // SLL
      vecs[5] = mk(5'd1,  5'd2,  5'd3,  4'b1001, 1'b0, 1'b1, 32'h0);          // alt SLL illegal
      vecs[6] = mk(5'd1,  5'd2,  5'd3,  4'b1111, 1'b0, 1'b1, 32'h0);          // alt AND illegal
      vecs[7] = mk(5'd1,  5'd2,  5'd3,  4'b1000, 1'b1, 1'b1, 32'h0);          // mext + alt
`ifdef INST_ENCODER_MEXT_EN
      vecs[8] = mk(5'd1,  5'd2,  5'd3,  4'b0000, 1'b1, 1'b0, 32'h023100B3);  // MUL
`else
      vecs[8] = mk(5'd1,  5'd2,  5'd3,  4'b0000, 1'b1, 1'b1, 32'h0);          // MUL rejected
`endif

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive_req(5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single requests: one-cycle latency, then pop.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive_req(vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].ctrl, vecs[i].mext);
         in_valid = 1'b1; out_ready = 1'b0;
         @(negedge clk);
         in_valid = 1'b0;
         if (vecs[i].ill) exp_err_cnt++;
         check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].ill));
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(!vecs[i].ill));
         check($sformatf("v%0d_count", i), 32'(count), vecs[i].ill ? 32'd0 : 32'd1);
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(exp_err_cnt));
         if (!vecs[i].ill) check($sformatf("v%0d_inst", i), out_inst, vecs[i].exp);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check($sformatf("v%0d_err_clear", i), 32'(err), 32'd0);
         check($sformatf("v%0d_drained", i), 32'(count), 32'd0);
      end

      // Five back-to-back requests into a stalled output, then drain in order.
      for (int k = 0; k < 5; k++) words[k] = add_word(5'(k + 1), 5'(k + 8), 5'(k + 16));
      begin
         int  next_req;
         bit  done;
         bit  do_push, do_pop;
         next_req = 0; done = 1'b0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            check("bb_count", 32'(count), 32'(exp_q.size()));
            check("bb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("bb_in_ready", 32'(in_ready), 32'(exp_q.size() != 4));
            if (exp_q.size() != 0) check("bb_inst", out_inst, exp_q[0]);
            if (next_req == 5 && exp_q.size() == 0) begin
               done = 1'b1;
               break;
            end
            out_ready = (cyc >= 8);
            in_valid  = (next_req < 5);
            if (next_req < 5) drive_req(5'(next_req + 1), 5'(next_req + 8), 5'(next_req + 16), 4'b0000, 1'b0);
            do_pop  = (exp_q.size() != 0) && out_ready;
            do_push = in_valid && (exp_q.size() != 4);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
               exp_q.push_back(words[next_req]);
               next_req++;
            end
         end
         in_valid = 1'b0; out_ready = 1'b0;
         if (!done) check("bb_timeout", 32'd0, 32'd1);
      end

      // Error counter saturates.
      @(negedge clk);
      drive_req(5'd1, 5'd1, 5'd1, 4'b1001, 1'b0);
      in_valid = 1'b1;
      repeat (260) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("sat_err_cnt", 32'(err_cnt), 32'd255);
      check("sat_count", 32'(count), 32'd0);

      // Reset mid-operation with three entries buffered and concurrent accept/pop.
      drive_req(5'd3, 5'd1, 5'd2, 4'b0000, 1'b0);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      check("post_rst_count", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
